// File: rtl/quiz_arbiter.sv
// quiz_arbiter: round controller for the two-player buzzer front end.
// Picks the first player to press while armed, breaks simultaneous presses
// with an alternating priority bit, then runs the answer window and cooldown.
module quiz_arbiter #(
    parameter int ANS_CMAX = 100_000_000,
    parameter int GAP_CMAX = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tr_start,
    input  logic       tr_ack,
    input  logic       tr_a,
    input  logic       tr_b,
    output logic       lock_a,
    output logic       lock_b,
    output logic [1:0] winner,
    output logic       tr_buz,
    output logic       tr_tmo,
    output logic       busy
);

    // Counter is sized for the longer of the two timed phases.
    localparam int CMAX = (ANS_CMAX > GAP_CMAX) ? ANS_CMAX : GAP_CMAX;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] ANS_LAST = CW'(ANS_CMAX - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CMAX - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_ANSWER = 2'd2;
    localparam logic [1:0] S_COOL   = 2'd3;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pri;
    logic [1:0]    r_winner;
    logic          r_lock;
    logic          r_buz;
    logic          r_tmo;
    logic          r_busy;

    logic [1:0]    w_stateNext;
    logic [CW-1:0] w_cntNext;
    logic          w_priNext;
    logic [1:0]    w_winnerNext;
    logic          w_buzNext;
    logic          w_tmoNext;

    // Next-state decode; presses beat a same-cycle ack, ack beats expiry.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_priNext    = r_pri;
        w_winnerNext = r_winner;
        w_buzNext    = 1'b0;
        w_tmoNext    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tr_start) begin
                    w_stateNext  = S_ARMED;
                    w_winnerNext = WIN_NONE;
                end
            end
            S_ARMED: begin
                if (tr_a && tr_b) begin
                    w_stateNext  = S_ANSWER;
                    w_winnerNext = r_pri ? WIN_B : WIN_A;
                    w_priNext    = ~r_pri;
                    w_buzNext    = 1'b1;
                end else if (tr_a) begin
                    w_stateNext  = S_ANSWER;
                    w_winnerNext = WIN_A;
                    w_buzNext    = 1'b1;
                end else if (tr_b) begin
                    w_stateNext  = S_ANSWER;
                    w_winnerNext = WIN_B;
                    w_buzNext    = 1'b1;
                end else if (tr_ack) begin
                    w_stateNext  = S_IDLE;
                end
            end
            S_ANSWER: begin
                w_cntNext = r_cnt + CNT_ONE;
                if (tr_ack) begin
                    w_stateNext = S_COOL;
                end else if (r_cnt == ANS_LAST) begin
                    w_stateNext = S_COOL;
                    w_tmoNext   = 1'b1;
                end
            end
            default: begin
                w_cntNext = r_cnt + CNT_ONE;
                if (r_cnt == GAP_LAST) begin
                    w_stateNext = S_IDLE;
                end
            end
        endcase
        if (w_stateNext != r_state) begin
            w_cntNext = '0;
        end
    end

    // State, counter and all outputs registered together so outputs follow the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_pri    <= 1'b0;
            r_winner <= WIN_NONE;
            r_lock   <= 1'b1;
            r_buz    <= 1'b0;
            r_tmo    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_pri    <= w_priNext;
            r_winner <= w_winnerNext;
            r_lock   <= (w_stateNext != S_ARMED);
            r_buz    <= w_buzNext;
            r_tmo    <= w_tmoNext;
            r_busy   <= (w_stateNext != S_IDLE);
        end
    end

    assign lock_a = r_lock;
    assign lock_b = r_lock;
    assign winner = r_winner;
    assign tr_buz = r_buz;
    assign tr_tmo = r_tmo;
    assign busy   = r_busy;

endmodule

// File: tb/tb_quiz_arbiter.sv
// tb_quiz_arbiter: directed table of per-cycle vectors plus hand-written
// sequences for timeout, ack-vs-expiry and asynchronous reset mid-round.
module tb_quiz_arbiter;

    localparam int ANS = 20;
    localparam int GAP = 5;

    logic       clk;
    logic       rst_n;
    logic       tr_start;
    logic       tr_ack;
    logic       tr_a;
    logic       tr_b;
    logic       lock_a;
    logic       lock_b;
    logic [1:0] winner;
    logic       tr_buz;
    logic       tr_tmo;
    logic       busy;

    int nVectors;
    int nMiss;

    typedef struct {
        logic       start;
        logic       ack;
        logic       a;
        logic       b;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    quiz_arbiter #(.ANS_CMAX(ANS), .GAP_CMAX(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tr_start (tr_start),
        .tr_ack   (tr_ack),
        .tr_a     (tr_a),
        .tr_b     (tr_b),
        .lock_a   (lock_a),
        .lock_b   (lock_b),
        .winner   (winner),
        .tr_buz   (tr_buz),
        .tr_tmo   (tr_tmo),
        .busy     (busy)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle {lock_a, lock_b, winner, tr_buz, tr_tmo, busy}
    function automatic logic [6:0] ex(input bit armed, input logic [1:0] w,
                                      input bit buz, input bit tmo, input bit bsy);
        return {~armed, ~armed, w, buz, tmo, bsy};
    endfunction

    function automatic void addVec(input logic s, input logic k, input logic a,
                                   input logic b, input logic [6:0] e);
        vec_t v;
        v.start = s; v.ack = k; v.a = a; v.b = b; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Four quiet cooldown cycles followed by the return to IDLE
    function automatic void addCoolTail(input logic [1:0] w);
        for (int i = 0; i < GAP - 1; i++) addVec(0, 0, 0, 0, ex(0, w, 0, 0, 1));
        addVec(0, 0, 0, 0, ex(0, w, 0, 0, 0));
    endfunction

    task automatic checkOutput(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {lock_a, lock_b, winner, tr_buz, tr_tmo, busy};
        nVectors++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got {lockA,lockB,win,buz,tmo,busy}=%b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock them in, sample 1 unit after the edge
    task automatic applyStimulus(input logic s, input logic k, input logic a, input logic b);
        tr_start = s; tr_ack = k; tr_a = a; tr_b = b;
        @(posedge clk);
        #1;
        tr_start = 0; tr_ack = 0; tr_a = 0; tr_b = 0;
    endtask

    initial begin
        nVectors = 0;
        nMiss    = 0;
        rst_n    = 1'b0;
        tr_start = 0; tr_ack = 0; tr_a = 0; tr_b = 0;

        // Single press round
        addVec(1, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
        addVec(0, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
        addVec(0, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
        addVec(0, 0, 1, 0, ex(0, 2'b01, 1, 0, 1));
        addVec(0, 0, 0, 0, ex(0, 2'b01, 0, 0, 1));
        addVec(0, 0, 0, 0, ex(0, 2'b01, 0, 0, 1));
        addVec(0, 0, 0, 0, ex(0, 2'b01, 0, 0, 1));
        addVec(0, 1, 0, 0, ex(0, 2'b01, 0, 0, 1));
        addCoolTail(2'b01);
        addVec(0, 0, 1, 0, ex(0, 2'b01, 0, 0, 0));
        // Tie with pri=0 -> A, pri becomes 1
        addVec(1, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
        addVec(0, 0, 1, 1, ex(0, 2'b01, 1, 0, 1));
        addVec(0, 1, 0, 0, ex(0, 2'b01, 0, 0, 1));
        addCoolTail(2'b01);
        // Tie with pri=1 -> B, pri back to 0
        addVec(1, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
        addVec(0, 0, 1, 1, ex(0, 2'b10, 1, 0, 1));
        addVec(0, 1, 0, 0, ex(0, 2'b10, 0, 0, 1));
        addCoolTail(2'b10);
        // B alone leaves pri at 0
        addVec(1, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
        addVec(0, 0, 0, 1, ex(0, 2'b10, 1, 0, 1));
        addVec(0, 1, 0, 0, ex(0, 2'b10, 0, 0, 1));
        addCoolTail(2'b10);
        // Tie confirms pri still 0; pri becomes 1; then ignored inputs
        addVec(1, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
        addVec(0, 0, 1, 1, ex(0, 2'b01, 1, 0, 1));
        addVec(1, 0, 0, 0, ex(0, 2'b01, 0, 0, 1));
        addVec(0, 0, 0, 1, ex(0, 2'b01, 0, 0, 1));
        addVec(0, 1, 0, 0, ex(0, 2'b01, 0, 0, 1));
        addVec(1, 0, 1, 1, ex(0, 2'b01, 0, 0, 1));
        for (int i = 0; i < GAP - 2; i++) addVec(0, 0, 0, 0, ex(0, 2'b01, 0, 0, 1));
        addVec(0, 0, 0, 0, ex(0, 2'b01, 0, 0, 0));
        addVec(0, 1, 0, 0, ex(0, 2'b01, 0, 0, 0));
        // Abort from ARMED, start in ARMED ignored
        addVec(1, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
        addVec(1, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
        addVec(0, 1, 0, 0, ex(0, 2'b00, 0, 0, 0));
        // Press beats same-cycle ack
        addVec(1, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
        addVec(0, 1, 0, 1, ex(0, 2'b10, 1, 0, 1));
        addVec(0, 1, 0, 0, ex(0, 2'b10, 0, 0, 1));
        addCoolTail(2'b10);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", ex(0, 2'b00, 0, 0, 0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].start, vecs[i].ack, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Timeout: ANSWER lasts ANS cycles, tr_tmo in first COOL cycle
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("tmo_entry", ex(0, 2'b01, 1, 0, 1));
        for (int i = 1; i < ANS; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("tmo_ans%0d", i), ex(0, 2'b01, 0, 0, 1));
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("tmo_pulse", ex(0, 2'b01, 0, 1, 1));
        for (int i = 1; i < GAP; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("tmo_cool%0d", i), ex(0, 2'b01, 0, 0, 1));
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("tmo_idle", ex(0, 2'b01, 0, 0, 0));

        // Ack on the last ANSWER cycle suppresses tr_tmo
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        for (int i = 1; i < ANS; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("ackl_ans", ex(0, 2'b10, 0, 0, 1));
        applyStimulus(0, 1, 0, 0);
        checkOutput("ackl_cool", ex(0, 2'b10, 0, 0, 1));
        for (int i = 1; i < GAP; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ackl_idle", ex(0, 2'b10, 0, 0, 0));

        // Reset mid-ANSWER is immediate; pri (currently 1) returns to 0
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rst_pre", ex(0, 2'b01, 0, 0, 1));
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", ex(0, 2'b00, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_start", ex(1, 2'b00, 0, 0, 1));
        applyStimulus(0, 0, 1, 1);
        checkOutput("rst_tie", ex(0, 2'b01, 1, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule

// File: doc/quiz_arbiter.md
# quiz_arbiter

Round controller for the two-player buzzer front end. Takes debounced one-cycle trigger pulses from the two `button` instances and decides which player pressed first, resolving ties fairly. It locks both buttons outside the arming window, fires the `buzzer` flash trigger for the winner, and sequences the answer window and cooldown. It sits between the button pair and the buzzer, under control of a host start/ack pair.

## Interface
- `ANS_CMAX`, default 100_000_000: answer-window length in clk cycles; must be ≥ 2.
- `GAP_CMAX`, default 10_000_000: cooldown length in clk cycles; must be ≥ 1.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tr_start` in 1: host one-cycle pulse; opens a round.
- `tr_ack` in 1: host one-cycle pulse; closes the answer window or aborts arming.
- `tr_a` in 1: player A debounced press pulse from `button`.
- `tr_b` in 1: player B debounced press pulse from `button`.
- `lock_a` out 1: drives `button.lock` of player A; 1 = ignore presses.
- `lock_b` out 1: same for player B.
- `winner` out 2: 00 none, 01 A, 10 B; 11 never driven.
- `tr_buz` out 1: one-cycle pulse to the buzzer flash trigger on a win.
- `tr_tmo` out 1: one-cycle pulse when the answer window expires.
- `busy` out 1: 1 whenever the state is not IDLE.

## Operation
- States: IDLE, ARMED, ANSWER, COOL. Registered `pri` tie-break bit: 0 = A wins ties, 1 = B wins ties.
- Counter `cnt` is `$clog2(max(ANS_CMAX,GAP_CMAX))` bits wide, unsigned. It is cleared on every state entry.
- IDLE:
  - `tr_start` → ARMED; `winner` cleared to 00.
  - Presses and `tr_ack` are ignored.
- ARMED:
  - Exactly one of `tr_a`/`tr_b` → ANSWER; `winner` = that player.
  - Both in the same cycle → winner is A if `pri`=0, else B; `pri` toggles. This is the only event that toggles `pri`.
  - Neither press, `tr_ack` → IDLE (abort); `winner` stays 00.
  - A press in the same cycle as `tr_ack` takes precedence; the ack is dropped.
  - `tr_start` is ignored. No arming timeout.
- ANSWER:
  - `cnt` increments each cycle.
  - `tr_ack` → COOL.
  - Else `cnt == ANS_CMAX-1` → COOL with `tr_tmo`.
  - Ack and expiry in the same cycle: ack wins, no `tr_tmo`.
  - Presses and `tr_start` are ignored.
- COOL: `cnt` increments; at `cnt == GAP_CMAX-1` → IDLE. All inputs are ignored.
- `winner` holds from the win until the next accepted `tr_start`. Reset clears it.
- `lock_a` = `lock_b` = 1 in every state except ARMED, where both are 0.

## Timing
- Reset values: state IDLE, `pri` 0, `cnt` 0, `winner` 00, `lock_a`/`lock_b` 1, `tr_buz` 0, `tr_tmo` 0, `busy` 0.
- Assertion of `rst_n` mid-round returns to the reset values immediately; no pulse is emitted.
- All outputs are registered.
- `tr_start` sampled at edge t: state ARMED and locks low from t+1. A press sampled at t itself is not seen.
- Press sampled at edge t in ARMED: at t+1, state ANSWER, `winner` valid, `tr_buz` high for exactly that cycle, locks high.
- Answer window with no ack: ANSWER occupies exactly ANS_CMAX cycles. `tr_tmo` is high during the first COOL cycle.
- COOL occupies exactly GAP_CMAX cycles, then IDLE.
- `tr_ack` sampled at edge t in ANSWER: COOL from t+1.
- `busy` tracks the registered state with no extra latency.
- Inputs are assumed synchronous one-cycle pulses, since `button` outputs them. A pulse wider than one cycle is treated as repeated pulses; only the first is acted on because the subsequent state ignores it.

## Test plan
Bench parameters: ANS_CMAX=20, GAP_CMAX=5.
- **Single press:** reset, then `tr_start`, then `tr_a` 3 cycles later → `winner`=01 and one-cycle `tr_buz` one cycle after `tr_a`; locks 1; `tr_ack` 4 cycles later → COOL 5 cycles → IDLE, `busy`=0, `winner` still 01.
- **Ties:** `tr_a`+`tr_b` simultaneous in ARMED → `winner`=01 and `pri` becomes 1. Next round, another tie → `winner`=10 and `pri` becomes 0. Next round, `tr_b` alone → 10 and `pri` unchanged.
- **Timeout and ack precedence:** win, then no ack → `tr_tmo` exactly 20 cycles after ANSWER entry, then IDLE 5 cycles later. Repeat with `tr_ack` on the 20th ANSWER cycle → no `tr_tmo`.
- **Ignored inputs and abort:** `tr_a` while IDLE, `tr_b` in ANSWER, and `tr_start` in ARMED/ANSWER/COOL → no state or `winner` change, no `tr_buz`. `tr_ack` in ARMED with no press → IDLE, `winner`=00.
- **Press vs ack:** `tr_b` and `tr_ack` in the same ARMED cycle → ANSWER, `winner`=10, `tr_buz` pulses.
- **Reset mid-round:** `rst_n` low during ANSWER → outputs return to reset values asynchronously. After release, `tr_start` begins a fresh round with `pri`=0.
